// File: rtl/pipe_pkg.sv
// Shared IF/ID pipeline types: beat layout, buffer occupancy states and the default bubble encoding.
// Pure declarations; no logic, no latency, no backpressure.
package pipe_pkg;

    localparam int          IFID_INSTR_W = 32;
    localparam int          IFID_PC_W    = 32;
    localparam logic [31:0] NOP_DEFAULT  = 32'h0000_0000;

    typedef struct packed {
        logic [IFID_INSTR_W-1:0] instr;
        logic [IFID_PC_W-1:0]    pc;
        logic [IFID_PC_W-1:0]    pcplus4;
    } if_id_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } ifid_st_e;

endpackage

// File: rtl/pipe_skid_buf.sv
// Main + skid register pair with occupancy FSM: 1-cycle latency, in order, flush empties both entries.
// Backpressure: SKID_EN=1 gives a flopped in_rdy_o (low only in SKID); SKID_EN=0 passes out_rdy_i through.
module pipe_skid_buf
    import pipe_pkg::*;
#(
    parameter type T       = logic,
    parameter bit  SKID_EN = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic flush_i,
    input  logic in_vld_i,
    output logic in_rdy_o,
    input  T     in_dat_i,
    output logic out_vld_o,
    input  logic out_rdy_i,
    output T     out_dat_o
);

    ifid_st_e state_q;
    T         main_q;
    T         skid_q;
    logic     rdy_q;
    logic     accept;
    logic     consume;

    // rdy_q resets low so nothing is accepted while reset is asserted
    assign in_rdy_o  = SKID_EN ? rdy_q : (rdy_q && (state_q == EMPTY || out_rdy_i));
    assign out_vld_o = (state_q != EMPTY);
    assign out_dat_o = main_q;
    assign accept    = in_vld_i && in_rdy_o && !flush_i;
    assign consume   = out_vld_o && out_rdy_i;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            rdy_q   <= 1'b0;
        end else if (flush_i) begin
            state_q <= EMPTY;
            rdy_q   <= 1'b1;
        end else begin
            rdy_q <= 1'b1;
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        main_q  <= in_dat_i;
                        state_q <= FULL;
                    end
                end
                FULL: begin
                    if (accept && consume) begin
                        main_q <= in_dat_i;
                    end else if (accept) begin
                        if (SKID_EN) begin
                            skid_q  <= in_dat_i;
                            state_q <= SKID;
                            rdy_q   <= 1'b0;
                        end
                    end else if (consume) begin
                        state_q <= EMPTY;
                    end
                end
                SKID: begin
                    if (consume) begin
                        main_q  <= skid_q;
                        state_q <= FULL;
                    end else begin
                        rdy_q <= 1'b0;
                    end
                end
                default: state_q <= EMPTY;
            endcase
        end
    end

endmodule

// File: rtl/if_id_stage_buf.sv
// IF/ID boundary buffer: fetch beat visible to decode one cycle after acceptance; flush kills all entries.
// Backpressure: stall_i or !out_ready holds the head; optional skid keeps in_ready a flop.
module if_id_stage_buf
    import pipe_pkg::*;
#(
    parameter int                 INSTR_W   = 32,
    parameter int                 PC_W      = 32,
    parameter bit                 SKID_EN   = 1'b1,
    parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(NOP_DEFAULT),
    parameter int                 CNT_W     = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               stall_i,
    input  logic               flush_i,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] instr_f,
    input  logic [PC_W-1:0]    pc_f,
    input  logic [PC_W-1:0]    pcplus4_f,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] instr_d,
    output logic [PC_W-1:0]    pc_d,
    output logic [PC_W-1:0]    pcplus4_d,
    output logic [CNT_W-1:0]   stall_cnt_o
);

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
        logic [PC_W-1:0]    pcplus4;
    } beat_t;

    beat_t            in_dat;
    beat_t            head;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign in_dat = '{instr: instr_f, pc: pc_f, pcplus4: pcplus4_f};

    pipe_skid_buf #(
        .T       (beat_t),
        .SKID_EN (SKID_EN)
    ) u_buf (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush_i   (flush_i),
        .in_vld_i  (in_valid),
        .in_rdy_o  (in_ready),
        .in_dat_i  (in_dat),
        .out_vld_o (out_valid),
        .out_rdy_i (out_ready && !stall_i),
        .out_dat_o (head)
    );

    // Internal data of an empty stage is stale; decode always sees a clean bubble.
    assign instr_d   = out_valid ? head.instr   : NOP_INSTR;
    assign pc_d      = out_valid ? head.pc      : '0;
    assign pcplus4_d = out_valid ? head.pcplus4 : '0;

    always_comb begin
        cnt_d = cnt_q;
        if (out_valid && (stall_i || !out_ready) && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign stall_cnt_o = cnt_q;

endmodule

// File: tb/tb_if_id_stage_buf.sv
// Directed bench for if_id_stage_buf: skid build (A) and non-skid 4-bit-counter build (B) with scoreboards.
module tb_if_id_stage_buf;

    logic        clk = 1'b0;
    logic        reset_n;
    always #5 clk = ~clk;

    logic        a_stall, a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [31:0] a_instr, a_pc, a_pc4, a_instr_d, a_pc_d, a_pc4_d;
    logic [15:0] a_cnt;

    logic        b_stall, b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [31:0] b_instr, b_pc, b_pc4, b_instr_d, b_pc_d, b_pc4_d;
    logic [3:0]  b_cnt;

    if_id_stage_buf #(.SKID_EN(1'b1), .CNT_W(16)) dut_a (
        .clk(clk), .reset_n(reset_n), .stall_i(a_stall), .flush_i(a_flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready),
        .instr_f(a_instr), .pc_f(a_pc), .pcplus4_f(a_pc4),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .instr_d(a_instr_d), .pc_d(a_pc_d), .pcplus4_d(a_pc4_d), .stall_cnt_o(a_cnt)
    );

    if_id_stage_buf #(.SKID_EN(1'b0), .CNT_W(4)) dut_b (
        .clk(clk), .reset_n(reset_n), .stall_i(b_stall), .flush_i(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .instr_f(b_instr), .pc_f(b_pc), .pcplus4_f(b_pc4),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .instr_d(b_instr_d), .pc_d(b_pc_d), .pcplus4_d(b_pc4_d), .stall_cnt_o(b_cnt)
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;
    int   checks   = 0;
    int   failures = 0;
    bit   inv_en   = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic v, input logic [31:0] pc);
        a_in_valid = v;
        a_pc       = pc;
        a_pc4      = pc + 32'd4;
        a_instr    = 32'hA000_0000 | pc;
    endtask

    task automatic drive_b(input logic v, input logic [31:0] pc);
        b_in_valid = v;
        b_pc       = pc;
        b_pc4      = pc + 32'd4;
        b_instr    = 32'hB000_0000 | pc;
    endtask

    // Scoreboard monitor: pops on every consumed head, pushes every accepted fetch beat.
    always @(negedge clk) begin
        if (reset_n) begin
            if (a_flush) begin
                qa.delete();
            end else begin
                if (a_out_valid && a_out_ready && !a_stall) begin
                    if (qa.size() == 0) begin
                        chk("a_unexpected_beat_pc", {32'h0, a_pc_d}, 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        ea = qa.pop_front();
                        chk("a_beat_pc", {32'h0, a_pc_d}, {32'h0, ea.pc});
                        chk("a_beat_instr_pc4", {a_instr_d, a_pc4_d}, {ea.instr, ea.pc4});
                    end
                end
                if (a_in_valid && a_in_ready) qa.push_back('{a_instr, a_pc, a_pc4});
            end
            if (b_flush) begin
                qb.delete();
            end else begin
                if (b_out_valid && b_out_ready && !b_stall) begin
                    if (qb.size() == 0) begin
                        chk("b_unexpected_beat_pc", {32'h0, b_pc_d}, 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        eb = qb.pop_front();
                        chk("b_beat_pc", {32'h0, b_pc_d}, {32'h0, eb.pc});
                        chk("b_beat_instr_pc4", {b_instr_d, b_pc4_d}, {eb.instr, eb.pc4});
                    end
                end
                if (b_in_valid && b_in_ready) qb.push_back('{b_instr, b_pc, b_pc4});
            end
            if (inv_en) chk("b_in_ready_rule", b_in_ready, !b_out_valid || (b_out_ready && !b_stall));
        end
    end

    initial begin
        reset_n = 1'b0;
        a_stall = 0; a_flush = 0; a_out_ready = 0;
        b_stall = 0; b_flush = 0; b_out_ready = 0;
        drive_b(1'b0, 32'h0);
        a_in_valid = 1'b1; a_instr = 32'h2002_0005; a_pc = 32'h40; a_pc4 = 32'h44;

        // 1: reset holds a bubble and refuses beats
        @(negedge clk);
        chk("rst_out_valid", a_out_valid, 1'b0);
        chk("rst_instr_d", a_instr_d, 32'h0);
        chk("rst_pc_d", {a_pc_d, a_pc4_d}, 64'h0);
        chk("rst_in_ready", a_in_ready, 1'b0);
        chk("rst_b_in_ready", b_in_ready, 1'b0);
        chk("rst_cnt", a_cnt, 16'd0);
        #2;
        reset_n    = 1'b1;
        a_in_valid = 1'b0;
        @(negedge clk);
        chk("rel_in_ready", a_in_ready, 1'b1);
        chk("rel_out_valid", a_out_valid, 1'b0);
        inv_en = 1'b1;
        tick();

        // 2: back-to-back stream, one cycle latency
        a_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i < 3) drive_a(1'b1, 32'(4 * i));
            else       drive_a(1'b0, 32'h0);
            @(negedge clk);
            chk("stream_in_ready", a_in_ready, 1'b1);
            if (i > 0) chk("stream_pc_d", {31'h0, a_out_valid, a_pc_d}, {31'h0, 1'b1, 32'(4 * (i - 1))});
            tick();
        end
        @(negedge clk);
        chk("stream_drained", a_out_valid, 1'b0);
        tick();

        // 3: stall with beat landing in skid
        drive_a(1'b1, 32'h10);
        tick();
        drive_a(1'b1, 32'h14);
        a_stall = 1'b1;
        @(negedge clk);
        chk("stall_pc_d_s1", a_pc_d, 32'h10);
        chk("stall_in_ready_s1", a_in_ready, 1'b1);
        tick();
        a_in_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("stall_in_ready_skid", a_in_ready, 1'b0);
            chk("stall_pc_hold", a_pc_d, 32'h10);
            tick();
        end
        a_stall = 1'b0;
        @(negedge clk);
        chk("stall_cnt_3", a_cnt, 16'd3);
        chk("stall_release_pc", a_pc_d, 32'h10);
        tick();
        @(negedge clk);
        chk("skid_to_main_pc", a_pc_d, 32'h14);
        chk("skid_freed_in_ready", a_in_ready, 1'b1);
        tick();
        @(negedge clk);
        chk("stall_drained", a_out_valid, 1'b0);
        tick();

        // 4: flush while in SKID with a fetch beat offered
        a_out_ready = 1'b0;
        drive_a(1'b1, 32'h20);
        tick();
        drive_a(1'b1, 32'h24);
        @(negedge clk);
        chk("fill_in_ready", a_in_ready, 1'b1);
        tick();
        drive_a(1'b1, 32'h18);
        a_flush = 1'b1;
        @(negedge clk);
        chk("skid_state_in_ready", a_in_ready, 1'b0);
        chk("skid_state_pc", a_pc_d, 32'h20);
        tick();
        a_flush = 1'b0;
        drive_a(1'b0, 32'h0);
        a_out_ready = 1'b1;
        @(negedge clk);
        chk("flush_out_valid", a_out_valid, 1'b0);
        chk("flush_instr_nop", a_instr_d, 32'h0);
        chk("flush_pc_zero", {a_pc_d, a_pc4_d}, 64'h0);
        chk("flush_in_ready", a_in_ready, 1'b1);
        chk("flush_cnt", a_cnt, 16'd5);
        tick();
        @(negedge clk);
        chk("flush_no_ghost", a_out_valid, 1'b0);
        tick();

        // 5: flush and stall together
        drive_a(1'b1, 32'h30);
        tick();
        a_in_valid = 1'b0;
        a_stall = 1'b1;
        a_flush = 1'b1;
        @(negedge clk);
        chk("fs_out_valid", a_out_valid, 1'b1);
        chk("fs_cnt_before", a_cnt, 16'd5);
        tick();
        a_flush = 1'b0;
        @(negedge clk);
        chk("fs_empty", a_out_valid, 1'b0);
        chk("fs_cnt_flush_cycle", a_cnt, 16'd6);
        tick();
        @(negedge clk);
        chk("fs_cnt_after", a_cnt, 16'd6);
        a_stall = 1'b0;
        tick();

        // 6: non-skid stream, then counter saturation at 4 bits
        b_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i < 3) drive_b(1'b1, 32'h100 + 32'(4 * i));
            else       drive_b(1'b0, 32'h0);
            @(negedge clk);
            chk("b_stream_in_ready", b_in_ready, 1'b1);
            if (i > 0) chk("b_stream_pc_d", {31'h0, b_out_valid, b_pc_d}, {31'h0, 1'b1, 32'h100 + 32'(4 * (i - 1))});
            tick();
        end
        drive_b(1'b1, 32'h200);
        tick();
        drive_b(1'b1, 32'h204);
        b_out_ready = 1'b0;
        @(negedge clk);
        chk("b_blocked_in_ready", b_in_ready, 1'b0);
        tick();
        b_out_ready = 1'b1;
        b_stall = 1'b1;
        for (int k = 0; k < 19; k++) tick();
        @(negedge clk);
        chk("b_cnt_saturated", b_cnt, 4'd15);
        chk("b_hold_pc", b_pc_d, 32'h200);
        b_stall = 1'b0;
        @(negedge clk);
        tick();
        b_in_valid = 1'b0;
        @(negedge clk);
        chk("b_next_pc", b_pc_d, 32'h204);
        chk("b_cnt_held", b_cnt, 4'd15);
        tick();
        @(negedge clk);
        chk("b_drained", b_out_valid, 1'b0);

        chk("a_queue_empty", 64'(qa.size()), 64'd0);
        chk("b_queue_empty", 64'(qb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
